// File: rtl/l1_tlb_pkg.sv
// Shared widths, refill FSM encoding and the tree-PLRU access rule for the L1 TLB.
package l1_tlb_pkg;

   localparam int WAYS  = 8;
   localparam int WAY_W = 3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_FILL  = 3'd4
   } refill_state_e;

   // Touching a way points every node on its path at the opposite subtree.
   function automatic logic [WAYS-1:0] plru_access(input logic [WAYS-1:0] plru,
                                                   input logic [WAY_W-1:0] way);
      logic [WAYS-1:0] nxt;
      nxt = plru;
      nxt[1]                          = ~way[2];
      nxt[{2'b01, way[2]}]            = ~way[1];
      nxt[{1'b1, way[2], way[1]}]     = ~way[0];
      return nxt;
   endfunction

endpackage

// File: rtl/l1_tlb_refill_ctrl_if.sv
// Request/response handshake between the L1 refill controller and the L2 TLB.
interface l1_tlb_refill_ctrl_if #(
   parameter int VPN_W = 27,
   parameter int PPN_W = 20
);
   logic             l2_req_valid;
   logic             l2_req_ready;
   logic [VPN_W-1:0] l2_req_vpn;
   logic             l2_resp_valid;
   logic [PPN_W-1:0] l2_resp_ppn;
   logic             l2_resp_fault;

   modport master (
      output l2_req_valid, l2_req_vpn,
      input  l2_req_ready, l2_resp_valid, l2_resp_ppn, l2_resp_fault
   );

   modport slave (
      input  l2_req_valid, l2_req_vpn,
      output l2_req_ready, l2_resp_valid, l2_resp_ppn, l2_resp_fault
   );
endinterface

// File: rtl/l1_tlb_plru_update.sv
// Combinational tree-PLRU update; passes the state through when not enabled.
module l1_tlb_plru_update
   import l1_tlb_pkg::*;
(
   input  logic [WAYS-1:0]  plru_in,
   input  logic [WAY_W-1:0] way,
   input  logic             en,
   output logic [WAYS-1:0]  plru_out
);

   always_comb begin
      plru_out = plru_in;
      if (en) plru_out = plru_access(plru_in, way);
   end

endmodule

// File: rtl/l1_tlb_refill_ctrl.sv
// L1 TLB valid/PLRU metadata owner and L2 refill sequencer.
//
// state | meaning
// IDLE  | accepting lookups; hits update PLRU, a miss captures vpn/victim way
// REQ   | l2_req_valid held with the captured vpn until l2_req_ready
// WAIT  | request accepted, waiting for the L2 response
// DRAIN | flushed after acceptance; swallow the outstanding response
// FILL  | single cycle writing the entry, setting valid and touching PLRU
module l1_tlb_refill_ctrl
   import l1_tlb_pkg::*;
#(
   parameter int VPN_W = 27,
   parameter int PPN_W = 20
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               lookup_valid,
   input  logic               lookup_hit,
   input  logic [WAY_W-1:0]   lookup_hit_way,
   input  logic [VPN_W-1:0]   lookup_vpn,
   input  logic               flush,
   input  logic [WAY_W-1:0]   repl_waddr,
   output logic [WAYS-1:0]    valid,
   output logic [WAYS-1:0]    plru_val,
   output logic               miss_busy,
   l1_tlb_refill_ctrl_if.master l2,
   output logic               entry_wen,
   output logic [WAY_W-1:0]   entry_waddr,
   output logic [VPN_W-1:0]   entry_wvpn,
   output logic [PPN_W-1:0]   entry_wppn,
   output logic               refill_done,
   output logic               refill_fault
);

   refill_state_e    state_q, state_d;
   logic [WAYS-1:0]  valid_q, valid_d;
   logic [WAYS-1:0]  plru_q, plru_d;
   logic [VPN_W-1:0] vpn_q, vpn_d;
   logic [PPN_W-1:0] ppn_q, ppn_d;
   logic [WAY_W-1:0] way_q, way_d;
   logic             fault_q, fault_d;
   logic             hit_en, fill_en;
   logic [WAYS-1:0]  plru_hit, plru_fill;

   l1_tlb_plru_update u_plru_hit (
      .plru_in (plru_q),
      .way     (lookup_hit_way),
      .en      (hit_en),
      .plru_out(plru_hit)
   );

   l1_tlb_plru_update u_plru_fill (
      .plru_in (plru_q),
      .way     (way_q),
      .en      (fill_en),
      .plru_out(plru_fill)
   );

   always_comb begin
      state_d = state_q;
      vpn_d   = vpn_q;
      ppn_d   = ppn_q;
      way_d   = way_q;
      fault_d = 1'b0;
      hit_en  = 1'b0;
      fill_en = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (lookup_valid && !flush) begin
               if (lookup_hit) begin
                  hit_en = 1'b1;
               end else begin
                  vpn_d   = lookup_vpn;
                  way_d   = repl_waddr;
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (flush)               state_d = l2.l2_req_ready ? ST_DRAIN : ST_IDLE;
            else if (l2.l2_req_ready) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (flush) begin
               state_d = l2.l2_resp_valid ? ST_IDLE : ST_DRAIN;
            end else if (l2.l2_resp_valid) begin
               if (l2.l2_resp_fault) begin
                  fault_d = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  ppn_d   = l2.l2_resp_ppn;
                  state_d = ST_FILL;
               end
            end
         end
         ST_DRAIN: begin
            if (l2.l2_resp_valid) state_d = ST_IDLE;
         end
         ST_FILL: begin
            fill_en = !flush && !reset;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      valid_d = valid_q;
      plru_d  = plru_q;
      if (flush) begin
         valid_d = '0;
         plru_d  = '0;
      end else if (fill_en) begin
         valid_d[way_q] = 1'b1;
         plru_d         = plru_fill;
      end else if (hit_en) begin
         plru_d = plru_hit;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         valid_q <= '0;
         plru_q  <= '0;
         vpn_q   <= '0;
         ppn_q   <= '0;
         way_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         plru_q  <= plru_d;
         vpn_q   <= vpn_d;
         ppn_q   <= ppn_d;
         way_q   <= way_d;
         fault_q <= fault_d;
      end
   end

   assign valid           = valid_q;
   assign plru_val        = plru_q;
   assign miss_busy       = (state_q != ST_IDLE);
   assign l2.l2_req_valid = (state_q == ST_REQ);
   assign l2.l2_req_vpn   = vpn_q;
   assign entry_wen       = fill_en;
   assign entry_waddr     = way_q;
   assign entry_wvpn      = vpn_q;
   assign entry_wppn      = ppn_q;
   assign refill_done     = fill_en;
   assign refill_fault    = fault_q;

endmodule

// File: tb/tb_l1_tlb_refill_ctrl.sv
// Randomized refill/hit/flush traffic checked against a tree-walk metadata model.
module tb_l1_tlb_refill_ctrl;

   localparam int VPN_W = 27;
   localparam int PPN_W = 20;

   logic             clk = 1'b0;
   logic             reset;
   logic             lookup_valid, lookup_hit, flush;
   logic [2:0]       lookup_hit_way, repl_waddr;
   logic [VPN_W-1:0] lookup_vpn;
   logic [7:0]       valid, plru_val;
   logic             miss_busy, entry_wen, refill_done, refill_fault;
   logic [2:0]       entry_waddr;
   logic [VPN_W-1:0] entry_wvpn;
   logic [PPN_W-1:0] entry_wppn;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] m_valid, m_plru;

   always #5 clk = ~clk;

   l1_tlb_refill_ctrl_if #(.VPN_W(VPN_W), .PPN_W(PPN_W)) l2 ();

   l1_tlb_refill_ctrl #(.VPN_W(VPN_W), .PPN_W(PPN_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .lookup_valid  (lookup_valid),
      .lookup_hit    (lookup_hit),
      .lookup_hit_way(lookup_hit_way),
      .lookup_vpn    (lookup_vpn),
      .flush         (flush),
      .repl_waddr    (repl_waddr),
      .valid         (valid),
      .plru_val      (plru_val),
      .miss_busy     (miss_busy),
      .l2            (l2.master),
      .entry_wen     (entry_wen),
      .entry_waddr   (entry_waddr),
      .entry_wvpn    (entry_wvpn),
      .entry_wppn    (entry_wppn),
      .refill_done   (refill_done),
      .refill_fault  (refill_fault)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Walk from the root: each node on the path points away from the used half.
   function automatic void m_access(input logic [2:0] w);
      int node;
      node = 1;
      for (int l = 2; l >= 0; l--) begin
         m_plru[node] = ~w[l];
         node = node * 2 + (w[l] ? 1 : 0);
      end
   endfunction

   function automatic void m_flush();
      m_valid = '0;
      m_plru  = '0;
   endfunction

   task automatic idle_inputs();
      lookup_valid     = 1'b0;
      lookup_hit       = 1'b0;
      flush            = 1'b0;
      l2.l2_req_ready  = 1'b0;
      l2.l2_resp_valid = 1'b0;
      l2.l2_resp_fault = 1'b0;
   endtask

   task automatic check_meta(input string tag);
      check_val({tag, "_valid"}, valid, m_valid);
      check_val({tag, "_plru"}, plru_val, m_plru);
   endtask

   task automatic do_hit(input logic [2:0] w);
      lookup_valid = 1'b1; lookup_hit = 1'b1; lookup_hit_way = w; lookup_vpn = VPN_W'($urandom);
      settle();
      check_val("hit_busy", miss_busy, 0);
      tick();
      idle_inputs();
      m_access(w);
      check_meta("hit");
      check_val("hit_busy_after", miss_busy, 0);
   endtask

   // mode: 0 none, 1 flush in REQ, 2 flush with ready, 3 flush in WAIT,
   //       4 flush with response, 5 flush in FILL
   task automatic do_miss(input logic [VPN_W-1:0] vpn, input logic [2:0] way,
                          input int ready_dly, input int resp_dly, input logic fault,
                          input logic [PPN_W-1:0] ppn, input int mode);
      logic drain;
      drain = 1'b0;
      lookup_valid = 1'b1; lookup_hit = 1'b0; lookup_vpn = vpn; repl_waddr = way;
      settle();
      check_val("miss_busy_idle", miss_busy, 0);
      tick();
      idle_inputs();
      repl_waddr = 3'($urandom);
      for (int i = 0; i < ready_dly; i++) begin
         lookup_valid = 1'($urandom); lookup_hit = 1'b1; lookup_hit_way = 3'($urandom);
         l2.l2_resp_valid = 1'($urandom);
         if (mode == 1) flush = 1'b1;
         settle();
         check_val("req_valid_hold", l2.l2_req_valid, 1);
         check_val("req_vpn_hold", l2.l2_req_vpn, vpn);
         tick();
         idle_inputs();
         if (mode == 1) begin
            m_flush();
            check_val("flush_req_valid", l2.l2_req_valid, 0);
            check_val("flush_req_busy", miss_busy, 0);
            check_meta("flush_req");
            return;
         end
      end
      l2.l2_req_ready = 1'b1;
      if (mode == 2) flush = 1'b1;
      settle();
      check_val("req_valid_acc", l2.l2_req_valid, 1);
      check_val("req_vpn_acc", l2.l2_req_vpn, vpn);
      tick();
      idle_inputs();
      if (mode == 2) begin
         m_flush();
         drain = 1'b1;
         check_meta("flush_acc");
         check_val("flush_acc_busy", miss_busy, 1);
      end
      check_val("req_dropped", l2.l2_req_valid, 0);
      for (int i = 0; i < resp_dly; i++) begin
         if (mode == 3 && i == 0) flush = 1'b1;
         settle();
         check_val("wait_busy", miss_busy, 1);
         check_val("wait_wen", entry_wen, 0);
         tick();
         flush = 1'b0;
         if (mode == 3 && i == 0) begin
            m_flush();
            drain = 1'b1;
            check_meta("flush_wait");
         end
      end
      l2.l2_resp_valid = 1'b1; l2.l2_resp_ppn = ppn; l2.l2_resp_fault = fault;
      if (mode == 4) flush = 1'b1;
      settle();
      check_val("resp_wen", entry_wen, 0);
      tick();
      idle_inputs();
      if (drain || mode == 4) begin
         if (mode == 4) m_flush();
         check_val("discard_busy", miss_busy, 0);
         check_val("discard_wen", entry_wen, 0);
         check_val("discard_done", refill_done, 0);
         check_val("discard_fault", refill_fault, 0);
         check_meta("discard");
         tick();
         check_val("discard_fault2", refill_fault, 0);
         return;
      end
      if (fault) begin
         check_val("fault_pulse", refill_fault, 1);
         check_val("fault_wen", entry_wen, 0);
         check_val("fault_busy", miss_busy, 0);
         check_meta("fault");
         tick();
         check_val("fault_pulse_end", refill_fault, 0);
         return;
      end
      check_val("fill_wen", entry_wen, 1);
      check_val("fill_waddr", entry_waddr, way);
      check_val("fill_wvpn", entry_wvpn, vpn);
      check_val("fill_wppn", entry_wppn, ppn);
      check_val("fill_done", refill_done, 1);
      check_val("fill_busy", miss_busy, 1);
      if (mode == 5) begin
         flush = 1'b1;
         settle();
         check_val("flush_fill_wen", entry_wen, 0);
         check_val("flush_fill_done", refill_done, 0);
      end
      tick();
      flush = 1'b0;
      if (mode == 5) m_flush();
      else begin
         m_valid[way] = 1'b1;
         m_access(way);
      end
      check_val("post_fill_done", refill_done, 0);
      check_val("post_fill_wen", entry_wen, 0);
      check_val("post_fill_busy", miss_busy, 0);
      check_meta("fill");
   endtask

   initial begin
      int mode, rdly, sdly;
      logic flt;
      reset = 1'b1;
      idle_inputs();
      lookup_hit_way = '0; lookup_vpn = '0; repl_waddr = '0; l2.l2_resp_ppn = '0;
      tick(); tick();
      reset = 1'b0;
      m_flush();
      check_meta("reset");
      check_val("reset_busy", miss_busy, 0);
      check_val("reset_req", l2.l2_req_valid, 0);
      check_val("reset_wen", entry_wen, 0);
      check_val("reset_done", refill_done, 0);
      check_val("reset_fault", refill_fault, 0);
      check_val("reset_waddr", entry_waddr, 0);
      check_val("reset_wvpn", entry_wvpn, 0);
      check_val("reset_wppn", entry_wppn, 0);

      do_miss(27'h123, 3'd0, 0, 2, 1'b0, 20'hABCDE, 0);
      check_val("tp_first_valid", valid, 8'h01);
      check_val("tp_first_plru", plru_val, 8'h16);
      do_hit(3'd5);
      check_val("tp_hit5_plru", plru_val, 8'h1C);
      do_miss(VPN_W'($urandom), 3'd2, 5, 1, 1'b1, PPN_W'($urandom), 0);
      do_miss(VPN_W'($urandom), 3'd6, 0, 3, 1'b0, PPN_W'($urandom), 3);
      for (int w = 0; w < 8; w++)
         do_miss(VPN_W'($urandom), 3'(w), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0,
                 PPN_W'($urandom), 0);
      check_val("all_valid", valid, 8'hFF);
      do_miss(VPN_W'($urandom), 3'd3, 1, 1, 1'b0, PPN_W'($urandom), 0);
      check_val("rewrite_valid", valid, 8'hFF);
      do_miss(VPN_W'($urandom), 3'd4, 0, 1, 1'b0, PPN_W'($urandom), 5);
      check_val("flush_fill_valid", valid, 8'h00);
      do_miss(VPN_W'($urandom), 3'd1, 2, 2, 1'b0, PPN_W'($urandom), 2);
      do_miss(VPN_W'($urandom), 3'd7, 1, 1, 1'b0, PPN_W'($urandom), 4);
      do_miss(VPN_W'($urandom), 3'd5, 2, 0, 1'b0, PPN_W'($urandom), 1);

      // miss coinciding with flush in IDLE is not captured
      do_hit(3'd2);
      lookup_valid = 1'b1; lookup_hit = 1'b0; flush = 1'b1; repl_waddr = 3'd1;
      tick();
      idle_inputs();
      m_flush();
      check_val("idle_flush_busy", miss_busy, 0);
      check_meta("idle_flush");

      // reset in WAIT, late response ignored
      do_hit(3'd6);
      lookup_valid = 1'b1; lookup_hit = 1'b0; lookup_vpn = VPN_W'($urandom); repl_waddr = 3'd2;
      tick();
      idle_inputs();
      l2.l2_req_ready = 1'b1;
      tick();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_flush();
      check_val("rst_mid_busy", miss_busy, 0);
      check_val("rst_mid_req", l2.l2_req_valid, 0);
      check_meta("rst_mid");
      l2.l2_resp_valid = 1'b1; l2.l2_resp_fault = 1'b0; l2.l2_resp_ppn = PPN_W'($urandom);
      tick();
      idle_inputs();
      check_val("rst_late_wen", entry_wen, 0);
      check_val("rst_late_busy", miss_busy, 0);
      check_val("rst_late_fault", refill_fault, 0);

      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            do_hit(3'($urandom));
         end else begin
            mode = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0;
            flt  = ($urandom_range(0, 4) == 0);
            if (flt && mode == 5) mode = 0;
            rdly = $urandom_range(0, 4);
            sdly = $urandom_range(0, 4);
            if (mode == 1 && rdly == 0) rdly = 1;
            if (mode == 3 && sdly == 0) sdly = 1;
            do_miss(VPN_W'($urandom), 3'($urandom), rdly, sdly, flt, PPN_W'($urandom), mode);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
